gpu_launch_sequencer: RTL and testbench
=======================================

# gpu_launch_sequencer

Host-side OBI initiator that drives the GPU controller's configuration-register port to launch one kernel end to end. On a launch pulse it writes a descriptor list of NUM_CFG address/data pairs, then writes the start register. It waits for the controller interrupt (bounded by a timeout), reads the status register, and writes the interrupt-clear register. It sits between a host CPU/DMA front-end and the `regs_req`/`regs_rsp` slave port of the GPU controller, and offloads the launch handshake from software.

## Interface
- `NUM_CFG`, default 4: number of descriptor writes per launch (≥1).
- `START_ADDR`, default 32'h0000_0000: start register address.
- `START_VAL`, default 32'h0000_0001: value written to start the kernel.
- `STATUS_ADDR`, default 32'h0000_0004: status register, read after the interrupt.
- `IRQ_CLR_ADDR`, default 32'h0000_0008: interrupt-clear register.
- `IRQ_CLR_VAL`, default 32'h0000_0001: value written to clear the interrupt.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum cycles spent in WAIT_IRQ. The counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `launch_i`  in  1  one-cycle launch request; honoured only in IDLE.
- `cfg_addr_i[NUM_CFG]`  in  32 each  descriptor addresses, sampled on an accepted launch.
- `cfg_data_i[NUM_CFG]`  in  32 each  descriptor data, sampled on an accepted launch.
- `regs_req`  obi_req_if.master  —  outputs `req`, `we`, `be[3:0]`, `addr[31:0]`, `wdata[31:0]`.
- `regs_rsp`  obi_rsp_if.slave  —  inputs `gnt`, `rvalid`, `rdata[31:0]`.
- `interrupt_i`  in  1  controller interrupt (level).
- `busy_o`  out  1  high from an accepted launch until `done_o`.
- `done_o`  out  1  one-cycle completion pulse.
- `timeout_o`  out  1  valid with `done_o`: 1 means the interrupt never arrived.
- `status_o`  out  32  last status read; held until the next accepted launch.

## Operation
- States and transitions:
  - IDLE → CFG on `launch_i`.
  - CFG → START after NUM_CFG writes, in index order 0..NUM_CFG-1.
  - START → WAIT_IRQ when the start write's `rvalid` arrives.
  - WAIT_IRQ → STATUS when the interrupt has been seen, or → DONE on timeout.
  - STATUS → CLEAR on read `rvalid`.
  - CLEAR → DONE on `rvalid`.
  - DONE → IDLE after one cycle.
- Descriptor addresses and data are latched into internal registers on accept; later input changes are ignored.
- OBI rules:
  - At most one outstanding transaction.
  - `req` stays high, with `addr`/`we`/`be`/`wdata` stable, until the cycle `gnt`=1.
  - `req` drops the cycle after the grant.
  - The next `req` is issued no earlier than the cycle after that transaction's `rvalid`.
  - `be`=4'hF always. `we`=1 for all accesses except the STATUS read. `wdata`=0 for reads.
- `rvalid` arriving outside an outstanding transaction is ignored.
- `rdata` is captured into `status_o` only on the STATUS read's `rvalid`.
- Interrupt latch:
  - `irq_seen` is set when `interrupt_i`=1 in START or WAIT_IRQ, so an early interrupt is not lost.
  - It is cleared on an accepted launch.
- Timeout:
  - The counter resets to 0 on entry to WAIT_IRQ and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES with `irq_seen`=0, the block goes to DONE with `timeout_o`=1 and `status_o`=0; STATUS and CLEAR are skipped.
  - If the interrupt and the terminal count occur in the same cycle, the interrupt wins (no timeout).
- `launch_i` while busy is dropped; there is no queueing.
- Reset values: `req`=0, `we`=0, `be`=0, `addr`=0, `wdata`=0, `busy_o`=0, `done_o`=0, `timeout_o`=0, `status_o`=0, state=IDLE, `irq_seen`=0, counter=0.
- Reset mid-transaction aborts immediately, with `req` low asynchronously. This is acceptable only under system-wide reset.

## Timing
- All outputs are registered; no combinational path from `gnt`/`rvalid` to `req`.
- Launch accepted at cycle 0 → first `req`=1 at cycle 1.
- Transaction cost with `gnt` on the request cycle and `rvalid` one cycle later: request at cycle n, `rvalid` at n+1, next request at n+2 (2 cycles per access).
- Best case from launch to `done_o` is 1 + 2·(NUM_CFG+3) + WAIT_IRQ dwell + 1 cycles:
  - WAIT_IRQ dwell is ≥1 cycle.
  - With defaults and the interrupt already seen: cycle 17.
- `busy_o` rises at cycle 1 and falls with the `done_o` cycle +1 (IDLE).
- Timeout fires exactly TIMEOUT_CYCLES cycles after WAIT_IRQ entry.

## Test plan
- **Nominal launch:** NUM_CFG=4, slave grants immediately with `rvalid` +1, interrupt 10 cycles after the start write, `rdata`=32'hCAFE_0001 → bus sequence is 4 descriptor writes in order, write START_VAL@0x0, read @0x4, write 1@0x8. Then `done_o`=1 with `timeout_o`=0 and `status_o`=32'hCAFE_0001.
- **Grant stall:** hold `gnt`=0 for 5 cycles on descriptor 2 → `req`/`addr`/`wdata` remain stable all 5 cycles, then the next request comes ≥2 cycles later. No second request is ever outstanding.
- **Early interrupt:** `interrupt_i` pulses for 1 cycle between the start grant and its `rvalid` → STATUS read still occurs and there is no timeout.
- **Timeout:** TIMEOUT_CYCLES=20, no interrupt → `done_o` exactly 20 cycles after WAIT_IRQ entry, `timeout_o`=1, `status_o`=0, no access to 0x4/0x8.
- **Launch while busy, and descriptor changes after accept:** → second launch ignored and written data equals the values sampled at accept.
- **Reset mid-CFG:** assert `rst_ni`=0 with `req` high → `req` and `busy_o` drop asynchronously. After release, a new launch runs the full nominal sequence.

Source files
------------

// File: rtl/gpu_launch_sequencer.sv
// OBI initiator that launches one GPU kernel end to end: descriptor writes, start write,
// bounded wait for the controller interrupt, status read and interrupt clear.
module gpu_launch_sequencer #(
    parameter int unsigned NUM_CFG        = 4,
    parameter logic [31:0] START_ADDR     = 32'h0000_0000,
    parameter logic [31:0] START_VAL      = 32'h0000_0001,
    parameter logic [31:0] STATUS_ADDR    = 32'h0000_0004,
    parameter logic [31:0] IRQ_CLR_ADDR   = 32'h0000_0008,
    parameter logic [31:0] IRQ_CLR_VAL    = 32'h0000_0001,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        launch_i,
    input  logic [31:0] cfg_addr_i [NUM_CFG],
    input  logic [31:0] cfg_data_i [NUM_CFG],
    output logic        regs_req_req,
    output logic        regs_req_we,
    output logic [3:0]  regs_req_be,
    output logic [31:0] regs_req_addr,
    output logic [31:0] regs_req_wdata,
    input  logic        regs_rsp_gnt,
    input  logic        regs_rsp_rvalid,
    input  logic [31:0] regs_rsp_rdata,
    input  logic        interrupt_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] status_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CFG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_START,
        S_WAIT_IRQ,
        S_STATUS,
        S_CLEAR,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      desc_addr_q [NUM_CFG];
    logic [31:0]      desc_data_q [NUM_CFG];
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             outstanding_q;
    logic             irq_seen_q;

    logic             accept;
    logic             granted;
    logic             rsp_done;
    logic             irq_now;

    logic             issue;
    logic             issue_we;
    logic [31:0]      issue_addr;
    logic [31:0]      issue_wdata;

    assign accept   = (state_q == S_IDLE) && launch_i;
    assign granted  = regs_req_req && regs_rsp_gnt;
    // A response only counts when a granted access is actually waiting for it.
    assign rsp_done = outstanding_q && regs_rsp_rvalid;
    assign irq_now  = irq_seen_q || interrupt_i;
    assign idx_nxt  = idx_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        issue_we    = 1'b1;
        issue_addr  = '0;
        issue_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (launch_i) begin
                    state_d     = S_CFG;
                    issue       = 1'b1;
                    issue_addr  = cfg_addr_i[0];
                    issue_wdata = cfg_data_i[0];
                end
            end
            S_CFG: begin
                if (rsp_done) begin
                    issue = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d     = S_START;
                        issue_addr  = START_ADDR;
                        issue_wdata = START_VAL;
                    end else begin
                        issue_addr  = desc_addr_q[idx_nxt];
                        issue_wdata = desc_data_q[idx_nxt];
                    end
                end
            end
            S_START: begin
                if (rsp_done) begin
                    state_d = S_WAIT_IRQ;
                end
            end
            S_WAIT_IRQ: begin
                // A same-cycle interrupt beats the terminal count.
                if (irq_now) begin
                    state_d = S_STATUS;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_STATUS: begin
                // The read goes out from inside STATUS, one cycle after the interrupt decision.
                if (!regs_req_req && !outstanding_q) begin
                    issue    = 1'b1;
                    issue_we = 1'b0;
                    issue_addr = STATUS_ADDR;
                end else if (rsp_done) begin
                    state_d     = S_CLEAR;
                    issue       = 1'b1;
                    issue_addr  = IRQ_CLR_ADDR;
                    issue_wdata = IRQ_CLR_VAL;
                end
            end
            S_CLEAR: begin
                if (rsp_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: descriptor storage has no reset; it is always written on accept before being read.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            desc_addr_q <= cfg_addr_i;
            desc_data_q <= cfg_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_req_req   <= 1'b0;
            regs_req_we    <= 1'b0;
            regs_req_be    <= 4'h0;
            regs_req_addr  <= '0;
            regs_req_wdata <= '0;
            outstanding_q  <= 1'b0;
            idx_q          <= '0;
            cnt_q          <= '0;
            irq_seen_q     <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
            status_o       <= '0;
        end else begin
            if (issue) begin
                regs_req_req   <= 1'b1;
                regs_req_we    <= issue_we;
                regs_req_be    <= 4'hF;
                regs_req_addr  <= issue_addr;
                regs_req_wdata <= issue_wdata;
            end else if (granted) begin
                regs_req_req <= 1'b0;
            end

            if (granted) begin
                outstanding_q <= 1'b1;
            end else if (rsp_done) begin
                outstanding_q <= 1'b0;
            end

            if (accept) begin
                idx_q <= '0;
            end else if ((state_q == S_CFG) && rsp_done && (idx_q != IDX_LAST)) begin
                idx_q <= idx_nxt;
            end

            if ((state_q == S_START) && rsp_done) begin
                cnt_q <= '0;
            end else if (state_q == S_WAIT_IRQ) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (accept) begin
                irq_seen_q <= 1'b0;
            end else if (((state_q == S_START) || (state_q == S_WAIT_IRQ)) && interrupt_i) begin
                irq_seen_q <= 1'b1;
            end

            if (accept) begin
                status_o <= '0;
            end else if ((state_q == S_STATUS) && rsp_done) begin
                status_o <= regs_rsp_rdata;
            end

            if (accept) begin
                busy_o <= 1'b1;
            end else if (state_q == S_DONE) begin
                busy_o <= 1'b0;
            end

            done_o    <= (state_d == S_DONE);
            timeout_o <= (state_q == S_WAIT_IRQ) && (state_d == S_DONE);
        end
    end

    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (regs_req_req && !regs_rsp_gnt) |=> (regs_req_req && $stable(regs_req_addr)
                                             && $stable(regs_req_wdata) && $stable(regs_req_we)));

    a_single_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(regs_req_req && outstanding_q));

endmodule

// File: tb/tb_gpu_launch_sequencer.sv
// Randomized scoreboard bench for gpu_launch_sequencer: a reactive OBI slave, a transaction
// monitor and a launch-level reference model of the expected bus traffic and completion.
module tb_gpu_launch_sequencer;

    localparam int          NUM_CFG      = 4;
    localparam int          TIMEOUT      = 20;
    localparam logic [31:0] START_ADDR   = 32'h0000_0000;
    localparam logic [31:0] START_VAL    = 32'h0000_0001;
    localparam logic [31:0] STATUS_ADDR  = 32'h0000_0004;
    localparam logic [31:0] IRQ_CLR_ADDR = 32'h0000_0008;
    localparam logic [31:0] IRQ_CLR_VAL  = 32'h0000_0001;
    localparam int          BEST_LAT     = 1 + 2 * (NUM_CFG + 3) + 1 + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          to;
        logic [31:0] status;
        int          lat;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        launch;
    logic [31:0] cfg_addr [NUM_CFG];
    logic [31:0] cfg_data [NUM_CFG];
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        interrupt;
    logic        busy, done, timeout;
    logic [31:0] status;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    txn_t  exp_q [$];
    done_t exp_done_q [$];

    // slave knobs and state
    int          lat_max = 1;
    int          stall_max = 0;
    int          irq_plan = -1;
    bit          stall_en = 1'b0;
    logic [31:0] stall_target = '0;
    logic [31:0] status_plan = '0;
    int          rsp_wait, stall_left, irq_cnt;
    bit          rsp_is_read, rsp_is_start;
    int          start_rv_cyc = 0;
    int          launch_cyc = 0;

    // monitor state
    bit          pend, mon_out;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    txn_t        mon_t;
    done_t       mon_e;

    gpu_launch_sequencer #(
        .NUM_CFG        (NUM_CFG),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .launch_i        (launch),
        .cfg_addr_i      (cfg_addr),
        .cfg_data_i      (cfg_data),
        .regs_req_req    (req),
        .regs_req_we     (we),
        .regs_req_be     (be),
        .regs_req_addr   (addr),
        .regs_req_wdata  (wdata),
        .regs_rsp_gnt    (gnt),
        .regs_rsp_rvalid (rvalid),
        .regs_rsp_rdata  (rdata),
        .interrupt_i     (interrupt),
        .busy_o          (busy),
        .done_o          (done),
        .timeout_o       (timeout),
        .status_o        (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic scramble_cfg();
        for (int i = 0; i < NUM_CFG; i++) begin
            cfg_addr[i] = $urandom;
            cfg_data[i] = $urandom;
        end
    endtask

    // Reactive OBI slave: random grant stalls, rvalid 1..lat_max cycles after grant,
    // stray rvalids while idle, and an interrupt pulse timed from the start-write grant.
    initial begin : slave
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; interrupt = 1'b0;
        rsp_wait = 0; stall_left = -1; irq_cnt = -1;
        rsp_is_read = 1'b0; rsp_is_start = 1'b0;
        forever begin
            @(negedge clk);
            rvalid = 1'b0;
            gnt = 1'b0;
            interrupt = 1'b0;
            if (!rst_n) begin
                rsp_wait = 0;
                stall_left = -1;
                irq_cnt = -1;
            end else begin
                if (irq_cnt > 0) begin
                    irq_cnt--;
                    if (irq_cnt == 0) begin
                        interrupt = 1'b1;
                        irq_cnt = -1;
                    end
                end
                if (rsp_wait > 0) begin
                    rsp_wait--;
                    if (rsp_wait == 0) begin
                        rvalid = 1'b1;
                        rdata = rsp_is_read ? status_plan : $urandom;
                        if (rsp_is_start) start_rv_cyc = cyc;
                    end
                end else if (req) begin
                    if (stall_left < 0)
                        stall_left = (stall_en && addr == stall_target) ? 5 : $urandom_range(0, stall_max);
                    if (stall_left == 0) begin
                        gnt = 1'b1;
                        stall_left = -1;
                        rsp_wait = $urandom_range(1, lat_max);
                        rsp_is_read = !we;
                        rsp_is_start = we && (addr == START_ADDR) && (wdata == START_VAL);
                        if (rsp_is_start && irq_plan == 0) interrupt = 1'b1;
                        else if (rsp_is_start && irq_plan > 0) irq_cnt = irq_plan;
                    end else begin
                        stall_left--;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    rvalid = 1'b1;
                    rdata = $urandom;
                end
            end
        end
    end

    // Monitor: protocol rules every cycle, scoreboard pop on each granted request and on done.
    initial begin : monitor
        pend = 1'b0;
        mon_out = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pend = 1'b0;
                mon_out = 1'b0;
            end else begin
                if (pend) begin
                    check_bit("req_held", req, 1'b1);
                    check("addr_stable", addr, p_addr);
                    check("wdata_stable", wdata, p_wdata);
                    check_bit("we_stable", we, p_we);
                end
                if (mon_out) check_bit("no_req_while_outstanding", req, 1'b0);
                if (req && gnt) begin
                    check_bit("txn_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        mon_t = exp_q.pop_front();
                        check("txn_addr", addr, mon_t.addr);
                        check_bit("txn_we", we, mon_t.we);
                        check("txn_wdata", wdata, mon_t.wdata);
                        check("txn_be", 32'(be), 32'hF);
                    end
                    mon_out = 1'b1;
                end else if (rvalid && mon_out) begin
                    mon_out = 1'b0;
                end
                pend = req && !gnt;
                p_addr = addr;
                p_wdata = wdata;
                p_we = we;
                if (done) begin
                    check_bit("done_expected", exp_done_q.size() != 0, 1'b1);
                    if (exp_done_q.size() != 0) begin
                        mon_e = exp_done_q.pop_front();
                        check_bit("timeout_flag", timeout, mon_e.to);
                        check("status", status, mon_e.status);
                        check_bit("busy_at_done", busy, 1'b1);
                        if (mon_e.lat >= 0) check("done_latency", cyc - launch_cyc, mon_e.lat);
                        if (mon_e.to) check("timeout_dwell", cyc - start_rv_cyc, 1 + TIMEOUT);
                    end
                end
            end
        end
    end

    task automatic run_launch(input bit with_irq, input int irq_delay, input int lat_m,
                              input int stall_m, input int stall_idx, input bit poke,
                              input int exp_lat, input logic [31:0] st_val, input bit abort_cfg);
        logic [31:0] a [NUM_CFG];
        logic [31:0] d [NUM_CFG];
        int n;
        for (int i = 0; i < NUM_CFG; i++) begin
            a[i] = $urandom | 32'h0000_1000;
            d[i] = $urandom;
        end
        // Reference model: the whole expected bus trace and completion of this launch.
        for (int i = 0; i < NUM_CFG; i++) exp_q.push_back('{a[i], 1'b1, d[i]});
        exp_q.push_back('{START_ADDR, 1'b1, START_VAL});
        if (with_irq) begin
            exp_q.push_back('{STATUS_ADDR, 1'b0, 32'h0});
            exp_q.push_back('{IRQ_CLR_ADDR, 1'b1, IRQ_CLR_VAL});
        end
        exp_done_q.push_back('{!with_irq, with_irq ? st_val : 32'h0, exp_lat});

        lat_max = lat_m;
        stall_max = stall_m;
        irq_plan = with_irq ? irq_delay : -1;
        status_plan = st_val;
        stall_en = (stall_idx >= 0);
        stall_target = (stall_idx >= 0) ? a[stall_idx] : 32'h0;

        @(negedge clk);
        cfg_addr = a;
        cfg_data = d;
        launch = 1'b1;
        launch_cyc = cyc;
        @(negedge clk);
        launch = 1'b0;
        scramble_cfg();
        check_bit("busy_rise", busy, 1'b1);

        if (abort_cfg) begin
            n = 0;
            while (!req && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_bit("req_before_reset", req, 1'b1);
            #3 rst_n = 1'b0;
            #1;
            check_bit("req_async_drop", req, 1'b0);
            check_bit("busy_async_drop", busy, 1'b0);
            exp_q.delete();
            exp_done_q.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            return;
        end

        if (poke) begin
            repeat (3) @(negedge clk);
            launch = 1'b1;
            scramble_cfg();
            @(negedge clk);
            launch = 1'b0;
            scramble_cfg();
        end

        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_bit("done_arrived", done, 1'b1);
        if (!done) begin
            exp_q.delete();
            exp_done_q.delete();
        end else begin
            @(negedge clk);
            check_bit("done_one_cycle", done, 1'b0);
            check_bit("busy_fall", busy, 1'b0);
        end
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        launch = 1'b0;
        scramble_cfg();
        repeat (3) @(negedge clk);
        check_bit("rst_req", req, 1'b0);
        check_bit("rst_we", we, 1'b0);
        check("rst_be", 32'(be), 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_timeout", timeout, 1'b0);
        check("rst_status", status, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // best case: immediate grant, rvalid +1, interrupt seen during the start write
        run_launch(1'b1, 0, 1, 0, -1, 1'b0, BEST_LAT, $urandom, 1'b0);
        // nominal: interrupt 10 cycles after the start write
        run_launch(1'b1, 10, 1, 0, -1, 1'b0, -1, 32'hCAFE_0001, 1'b0);
        // grant stall of 5 cycles on descriptor 2
        run_launch(1'b1, 4, 1, 0, 2, 1'b0, -1, $urandom, 1'b0);
        // early interrupt pulse between start grant and its rvalid
        run_launch(1'b1, 0, 3, 0, -1, 1'b0, -1, $urandom, 1'b0);
        // timeout: no interrupt ever
        run_launch(1'b0, 0, 1, 0, -1, 1'b0, -1, $urandom, 1'b0);
        run_launch(1'b0, 0, 3, 2, -1, 1'b0, -1, $urandom, 1'b0);
        // launch while busy with descriptor inputs changing after accept
        run_launch(1'b1, 6, 2, 1, -1, 1'b1, -1, $urandom, 1'b0);
        // reset mid-CFG, then a full nominal launch
        run_launch(1'b1, 3, 1, 1, -1, 1'b0, -1, $urandom, 1'b1);
        run_launch(1'b1, 10, 1, 0, -1, 1'b0, -1, 32'hCAFE_0001, 1'b0);

        for (int k = 0; k < 16; k++) begin
            run_launch($urandom_range(0, 3) != 0, $urandom_range(0, 10), 3, 3, -1,
                       $urandom_range(0, 3) == 0, -1, $urandom, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("exp_txn_drained", exp_q.size(), 32'd0);
        check("exp_done_drained", exp_done_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
